// File: rtl/pio_loader_if.sv
// Image-memory read port and pio command port of the loader, bundled together.
// The master side (the loader) drives reads and commands; the slave side returns read data.
`timescale 1ns/1ps
interface pio_loader_if #(
    parameter int ADDR_W = 8
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic [3:0]        action;
    logic [1:0]        mindex;
    logic [4:0]        index;
    logic [31:0]       din;

    modport master (
        output mem_rd, mem_addr, action, mindex, index, din,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd, mem_addr, action, mindex, index, din,
        output mem_rdata
    );
endinterface

// File: rtl/pio_loader.sv
// Replays a packed program/config image from synchronous memory as single-cycle
// pio command actions: quiesce, instructions, optional machine config, optional enable.
`timescale 1ns/1ps
module pio_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    pio_loader_if.master      bus,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [3:0] ACT_NONE  = 4'd0;
    localparam logic [3:0] ACT_INSTR = 4'd1;
    localparam logic [3:0] ACT_PEND  = 4'd2;
    localparam logic [3:0] ACT_GRPS  = 4'd5;
    localparam logic [3:0] ACT_EN    = 4'd6;
    localparam logic [3:0] ACT_DIV   = 4'd7;
    localparam logic [3:0] ACT_SHIFT = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_HDR, S_HDR, S_QUIESCE, S_FETCH, S_ISSUE, S_DONE
    } state_t;

    typedef enum logic [1:0] {DIN_ZERO, DIN_LO16, DIN_FULL} din_sel_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              err_q, err_d;
    logic [4:0]        offset_q, offset_d;
    logic [5:0]        count_q, count_d;
    logic              cfg_q, cfg_d;
    logic              en_q, en_d;
    logic [1:0]        mindex_q, mindex_d;
    logic [5:0]        k_q, k_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        action_q, action_d;
    logic [4:0]        index_q, index_d;
    din_sel_t          din_sel_q, din_sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [4:0] hdr_offset;
    logic [5:0] hdr_count;
    logic [5:0] hdr_sum;
    logic       hdr_bad;
    logic [5:0] total;
    logic [5:0] rel;

    // count <= 32 keeps the 6-bit sum from wrapping, so both tests together are exact.
    assign hdr_offset = bus.mem_rdata[4:0];
    assign hdr_count  = bus.mem_rdata[10:5];
    assign hdr_sum    = {1'b0, hdr_offset} + hdr_count;
    assign hdr_bad    = (hdr_count > 6'd32) || (hdr_sum > 6'd32);
    assign total      = count_q + (cfg_q ? 6'd4 : 6'd0) + {5'd0, en_q};

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        err_d    = err_q;
        offset_d = offset_q;
        count_d  = count_q;
        cfg_d    = cfg_q;
        en_d     = en_q;
        mindex_d = mindex_q;
        k_d      = k_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    err_d   = 1'b0;
                    state_d = S_RD_HDR;
                end
            end
            S_RD_HDR: state_d = S_HDR;
            S_HDR: begin
                offset_d = hdr_offset;
                count_d  = hdr_count;
                mindex_d = bus.mem_rdata[12:11];
                cfg_d    = bus.mem_rdata[13];
                en_d     = bus.mem_rdata[14];
                k_d      = '0;
                if (hdr_bad) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_QUIESCE;
                end
            end
            S_QUIESCE: state_d = (total == 6'd0) ? S_DONE : S_FETCH;
            S_FETCH:   state_d = S_ISSUE;
            S_ISSUE: begin
                k_d     = k_q + 6'd1;
                state_d = (k_q + 6'd1 == total) ? S_DONE : S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) begin
            mindex_d = '0;
        end

        // Outputs are registered: decode them for the state being entered.
        mem_rd_d   = 1'b0;
        mem_addr_d = '0;
        action_d   = ACT_NONE;
        index_d    = '0;
        din_sel_d  = DIN_ZERO;
        rel        = k_d - count_q;

        unique case (state_d)
            S_RD_HDR: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = base_d;
            end
            S_FETCH: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = base_q + ADDR_W'(k_d) + ADDR_W'(1);
            end
            S_QUIESCE: action_d = ACT_EN;
            S_ISSUE: begin
                if (k_d < count_q) begin
                    action_d  = ACT_INSTR;
                    index_d   = offset_q + k_d[4:0];
                    din_sel_d = DIN_LO16;
                end else begin
                    din_sel_d = DIN_FULL;
                    if (cfg_q && rel < 6'd4) begin
                        unique case (rel[1:0])
                            2'd0:    action_d = ACT_PEND;
                            2'd1:    action_d = ACT_GRPS;
                            2'd2:    action_d = ACT_SHIFT;
                            default: action_d = ACT_DIV;
                        endcase
                    end else begin
                        action_d = ACT_EN;
                    end
                end
            end
            default: ;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            err_q      <= 1'b0;
            offset_q   <= '0;
            count_q    <= '0;
            cfg_q      <= 1'b0;
            en_q       <= 1'b0;
            mindex_q   <= '0;
            k_q        <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            action_q   <= ACT_NONE;
            index_q    <= '0;
            din_sel_q  <= DIN_ZERO;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            err_q      <= err_d;
            offset_q   <= offset_d;
            count_q    <= count_d;
            cfg_q      <= cfg_d;
            en_q       <= en_d;
            mindex_q   <= mindex_d;
            k_q        <= k_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            action_q   <= action_d;
            index_q    <= index_d;
            din_sel_q  <= din_sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Read data only arrives in the ISSUE cycle, so the payload is steered, not registered.
    assign bus.din = (din_sel_q == DIN_FULL) ? bus.mem_rdata :
                     (din_sel_q == DIN_LO16) ? {16'h0, bus.mem_rdata[15:0]} : 32'h0;

    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.action   = action_q;
    assign bus.mindex   = mindex_q;
    assign bus.index    = index_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
endmodule

// File: tb/tb_pio_loader.sv
// Directed and randomized image loads checked against an image-walking reference model.
`timescale 1ns/1ps
module tb_pio_loader;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              busy, done, err;

    pio_loader_if #(.ADDR_W(ADDR_W)) bus ();

    pio_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];

    // Synchronous image memory; garbage on idle cycles so stale data cannot pass.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
        else            bus.mem_rdata <= $urandom;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [42:0] got_q[$];
    logic [42:0] exp_q[$];
    logic [7:0]  got_rd[$];
    logic [7:0]  exp_rd[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          viol = 0;
    int          exp_lat;
    logic        exp_err;
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk) begin
        if (bus.action != 4'd0) got_q.push_back({bus.action, bus.mindex, bus.index, bus.din});
        if (bus.mem_rd) got_rd.push_back(bus.mem_addr);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.action == 4'd0 && (bus.index != 5'd0 || bus.din != 32'd0)) viol++;
        if (bus.action != 4'd1 && bus.index != 5'd0) viol++;
        if (!bus.mem_rd && bus.mem_addr != 8'd0) viol++;
        if (!busy && (bus.action != 4'd0 || bus.mem_rd || bus.mindex != 2'd0 || done)) viol++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Walks the image the way the header describes it and lists the expected actions.
    task automatic model(input logic [7:0] base);
        logic [31:0] hdr;
        int          off, cnt, w;
        logic [1:0]  mi;
        logic [7:0]  a;
        logic [3:0]  cfg_codes [4];
        cfg_codes[0] = 4'd2; cfg_codes[1] = 4'd5; cfg_codes[2] = 4'd10; cfg_codes[3] = 4'd7;
        hdr = mem[base];
        off = int'(hdr[4:0]);
        cnt = int'(hdr[10:5]);
        mi  = hdr[12:11];
        exp_q.delete();
        exp_rd.delete();
        exp_rd.push_back(base);
        if (cnt > 32 || off + cnt > 32) begin
            exp_err = 1'b1;
            exp_lat = 3;
        end else begin
            exp_err = 1'b0;
            exp_q.push_back({4'd6, mi, 5'd0, 32'd0});
            w = 0;
            for (int i = 0; i < cnt; i++) begin
                w++;
                a = base + 8'(w);
                exp_rd.push_back(a);
                exp_q.push_back({4'd1, mi, 5'(off + i), 16'h0, mem[a][15:0]});
            end
            if (hdr[13]) begin
                for (int j = 0; j < 4; j++) begin
                    w++;
                    a = base + 8'(w);
                    exp_rd.push_back(a);
                    exp_q.push_back({cfg_codes[j], mi, 5'd0, mem[a]});
                end
            end
            if (hdr[14]) begin
                w++;
                a = base + 8'(w);
                exp_rd.push_back(a);
                exp_q.push_back({4'd6, mi, 5'd0, mem[a]});
            end
            exp_lat = 4 + 2 * w;
        end
    endtask

    function automatic logic [31:0] mk_hdr(int off, int cnt, int mi, bit cfg, bit en);
        logic [31:0] h;
        h        = $urandom;
        h[4:0]   = off[4:0];
        h[10:5]  = cnt[5:0];
        h[12:11] = mi[1:0];
        h[13]    = cfg;
        h[14]    = en;
        return h;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
    endtask

    task automatic run_load(input string tag, input logic [7:0] base, input int extra_at);
        int t0, prev, n_cmp;
        bit seen;
        model(base);
        got_q.delete();
        got_rd.delete();
        prev = done_cnt;
        @(negedge clk);
        base_addr = base;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        base_addr = $urandom;
        chk({tag, " busy"}, busy, 1);
        chk({tag, " err_clear"}, err, 0);
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(posedge clk);
            #2;
            start = (extra_at > 0 && cyc == t0 + extra_at);
            if (start) base_addr = $urandom;
            if (done_cnt != prev) seen = 1'b1;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, seen, 1);
        repeat (2) @(posedge clk);
        #2;
        chk({tag, " done_pulses"}, done_cnt - prev, 1);
        chk({tag, " latency"}, done_cyc - t0, exp_lat);
        chk({tag, " err"}, err, exp_err);
        chk({tag, " idle"}, busy, 0);
        chk({tag, " n_actions"}, got_q.size(), exp_q.size());
        n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) chk($sformatf("%s action%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, " n_reads"}, got_rd.size(), exp_rd.size());
        n_cmp = (got_rd.size() < exp_rd.size()) ? got_rd.size() : exp_rd.size();
        for (int i = 0; i < n_cmp; i++) chk($sformatf("%s read%0d", tag, i), got_rd[i], exp_rd[i]);
        $display("load %s base=%02h actions=%0d reads=%0d lat=%0d err=%0b", tag, base,
                 got_q.size(), got_rd.size(), done_cyc - t0, err);
    endtask

    initial begin
        int t0;
        logic [7:0] b;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {bus.action, bus.mindex, bus.index, bus.din, bus.mem_rd, bus.mem_addr,
                              busy, done, err}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        fill_mem();
        mem[8'h10] = mk_hdr(3, 2, 1, 1'b1, 1'b1);
        mem[8'h11] = {16'($urandom), 16'hE081};
        mem[8'h12] = {16'($urandom), 16'h0001};
        mem[8'h17] = 32'h0000_0002;
        run_load("plan_full", 8'h10, 0);

        fill_mem();
        mem[8'h20] = mk_hdr(7, 0, 2, 1'b0, 1'b0);
        run_load("empty", 8'h20, 0);

        fill_mem();
        mem[8'h30] = mk_hdr(30, 3, 3, 1'b1, 1'b1);
        run_load("overflow", 8'h30, 0);

        fill_mem();
        mem[8'h31] = mk_hdr(0, 5, 0, 1'b0, 1'b1);
        run_load("after_err", 8'h31, 0);

        fill_mem();
        mem[8'hFF] = mk_hdr(9, 1, 2, 1'b0, 1'b1);
        run_load("wrap", 8'hFF, 0);

        fill_mem();
        mem[8'h50] = mk_hdr(31, 63, 1, 1'b0, 1'b0);
        run_load("cnt_wrap", 8'h50, 0);

        fill_mem();
        mem[8'h60] = mk_hdr(20, 12, 3, 1'b1, 1'b0);
        run_load("edge32", 8'h60, 0);

        fill_mem();
        mem[8'h70] = mk_hdr(4, 3, 2, 1'b1, 1'b1);
        run_load("restart_busy", 8'h70, 6);

        for (int r = 0; r < 8; r++) begin
            fill_mem();
            b = 8'($urandom);
            mem[b] = mk_hdr(int'($urandom_range(0, 31)), int'($urandom_range(0, 36)),
                            int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            run_load($sformatf("rand%0d", r), b, (r % 3 == 0) ? 3 : 0);
        end

        // Reset asserted during the second ISSUE of a four-instruction load.
        fill_mem();
        mem[8'h40] = mk_hdr(5, 4, 2, 1'b0, 1'b0);
        @(negedge clk);
        base_addr = 8'h40;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("rst_mid action", {bus.action, bus.index, bus.din}, {4'd1, 5'd6, 16'h0, mem[8'h42][15:0]});
        reset = 1'b0;
        #1;
        chk("rst_mid outputs", {bus.action, bus.mindex, bus.index, bus.din, bus.mem_rd, bus.mem_addr,
                                busy, done, err}, 64'd0);
        $display("reset mid-load at cycle offset %0d", cyc - t0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        fill_mem();
        mem[8'h40] = mk_hdr(5, 4, 2, 1'b1, 1'b1);
        run_load("post_reset", 8'h40, 0);

        chk("protocol invariants", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
